replay_buffer_ctrl: RTL
=======================

Name: replay_buffer_ctrl

Overview:
- Parametrised data-link-layer replay buffer for the TX path.
- Accepts TLPs from the transaction layer and tags each with a sequence number. Forwards them to the link and keeps every TLP until it is acknowledged.
- Purges on ACK/NAK DLLPs, and replays all unacknowledged TLPs on NAK or on replay-timer expiry.
- Counts replays and requests link retrain on replay-number rollover.

Parameters:
- DATA_W, 64, TLP word width.
- DEPTH, 16, buffer entries; power of 2, at least 4, and below 2^(SEQ_W-1).
- SEQ_W, 12, sequence number width.
- TIMEOUT, 1024, replay timer expiry in clk cycles.
- REPLAY_MAX, 3, replays allowed before rollover.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- tx_valid  in  1  TLP offered
- tx_ready  out  1  buffer accepts TLP
- tx_data  in  DATA_W  TLP word
- tx_seq  out  SEQ_W  sequence number that will be assigned to the offered TLP (next_seq)
- out_valid  out  1  TLP to link valid
- out_ready  in  1  link accepts
- out_data  out  DATA_W  TLP word to link
- out_seq  out  SEQ_W  sequence number of out_data
- out_replay  out  1  current output is a replay
- dllp_valid  in  1  ACK/NAK received
- dllp_nak  in  1  0=ACK, 1=NAK
- dllp_seq  in  SEQ_W  AckNak_Seq_Num
- count  out  $clog2(DEPTH)+1  unacknowledged entries
- dllp_err  out  1  one-cycle pulse: invalid ACK/NAK sequence
- retrain_req  out  1  one-cycle pulse: replay number rollover

Behaviour:
- Reset: reset, asynchronous, active-low; clock clk. On reset, all pointers, count, next_seq, head_seq, timer and replay_num go to 0 and state goes to NORMAL.
  - Outputs in reset: tx_ready=0, out_valid=0, out_replay=0, dllp_err=0, retrain_req=0, out_data=0, out_seq=0.
  - Reset mid-operation discards all entries; no replay follows.
- Storage: circular array of {seq, data} with head (oldest unacked), send (next to transmit) and tail (write) pointers. All pointers are modulo DEPTH, and full/empty are derived from count.
- Write: tx_ready = (count<DEPTH) && state==NORMAL && no replay pending.
  - On tx_valid&&tx_ready, store {next_seq, tx_data} at tail; tail++; next_seq++ modulo 2^SEQ_W.
- Transmit: out_valid = (send!=tail). out_data/out_seq are read from entry[send]; send++ on out_valid&&out_ready.
  - A TLP accepted in cycle N is presented at N+1 at the earliest.
  - Outputs must hold stable while out_valid&&!out_ready.
- ACK/NAK decode, on dllp_valid: n = (dllp_seq - head_seq + 1) mod 2^SEQ_W.
  - n==0: duplicate, no purge.
  - 1<=n<=count: purge n entries (head+=n, head_seq+=n). If send lies before the new head, send=head.
  - n>count: pulse dllp_err and ignore the DLLP entirely, including its NAK.
- Forward progress (n>0): replay_num=0 and timer=0.
- Timer: increments each cycle while count>0 and state==NORMAL. It is held at 0 when count==0. Reaching TIMEOUT raises a replay request.
- Replay request sources: a valid NAK (after its purge) or timer expiry. Same-cycle NAK and expiry produce a single replay.
  - If the same-cycle DLLP made forward progress, the expiry is discarded.
- Replay start: latched as pending and applied on the first cycle with no stalled transfer (!out_valid || out_ready).
  - On start: send=head, state=REPLAY, timer=0, out_replay=1.
  - replay_num++; if the increment would exceed REPLAY_MAX, pulse retrain_req and set replay_num=0. The replay proceeds in either case.
  - If count==0 at start, the replay is cancelled.
- States: NORMAL, REPLAY.
  - REPLAY to NORMAL when send reaches the tail value captured at replay start (tail is frozen in REPLAY because writes are blocked), or when count becomes 0 via ACK. On exit, out_replay=0.
- ACK during REPLAY purges as normal.
- NAK during REPLAY re-arms a replay from the new head, applied under the same stall rule, and increments replay_num again.
- Simultaneous write and purge in one cycle: count = count + 1 - n.
- All sequence comparisons are modulo 2^SEQ_W and wrap at 4095→0 for the default SEQ_W.

Test Plan:
- Write 4 TLPs (seq 0-3), out_ready=1 → out_seq 0,1,2,3 on consecutive cycles; count=4; then ACK seq 1 → count=2 and head_seq=2.
- Fill DEPTH=16 with out_ready=0 → tx_ready=0 at count=16; ACK seq 15 → count=0 and tx_ready=1 next cycle.
- 3 outstanding (seq 5-7), NAK seq 5 → seq 5 purged; replay of seq 6,7 with out_replay=1; replay_num=1; then NORMAL.
- No ACK for 1024 cycles with 2 entries → replay starts; four consecutive timeouts → retrain_req pulses on the 4th and replay_num returns to 0.
- Sequence wrap: next_seq=4094, write 4 TLPs (4094, 4095, 0, 1), ACK seq 0 → count=1, head_seq=1.
- ACK seq 9 with head_seq=2 and count=3 → dllp_err pulse, no change to count or pointers; NAK with stall out_valid=1/out_ready=0 → replay waits until the stalled word is accepted.

Source files
------------

// File: rtl/replay_buffer_ctrl.sv
// TX-side data-link replay buffer: sequences TLPs, holds them until ACKed,
// replays unacknowledged entries on NAK or replay-timer expiry.
module replay_buffer_ctrl #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int SEQ_W      = 12,
    parameter int TIMEOUT    = 1024,
    parameter int REPLAY_MAX = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [DATA_W-1:0]        tx_data,
    output logic [SEQ_W-1:0]         tx_seq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic                     out_replay,
    input  logic                     dllp_valid,
    input  logic                     dllp_nak,
    input  logic [SEQ_W-1:0]         dllp_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dllp_err,
    output logic                     retrain_req
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(REPLAY_MAX + 2);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] REPLAY = 1'b1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [SEQ_W-1:0]  seq_mem  [DEPTH];

    logic [PW-1:0]    head, send, tail;
    logic [CW-1:0]    unsent;
    logic [SEQ_W-1:0] next_seq, head_seq;
    logic [TW-1:0]    timer;
    logic [RW-1:0]    replay_num;
    logic [0:0]       state;
    logic             pending, alive;

    // unsent counts entries between send and tail; kept explicitly so a
    // full buffer with nothing transmitted is distinguishable from empty
    assign tx_ready   = alive && (count < CW'(DEPTH)) && (state == NORMAL) && !pending;
    assign tx_seq     = next_seq;
    assign out_valid  = (unsent != '0);
    assign out_data   = out_valid ? data_mem[send] : '0;
    assign out_seq    = out_valid ? seq_mem[send] : '0;
    assign out_replay = (state == REPLAY);

    logic             wr, xfer, start, go, bad, good, purge, nak, expire, req, overflow;
    logic [SEQ_W-1:0] n;
    logic [CW-1:0]    n_c, count_p, count_nx, unsent_a, unsent_nx, sent_a;
    logic [PW-1:0]    head_nx, send_nx;
    logic [RW-1:0]    rnum_base, rnum_nx;
    logic [0:0]       state_nx;
    logic             pending_nx;
    logic [TW-1:0]    timer_nx;

    always_comb begin
        wr       = tx_valid && tx_ready;
        xfer     = out_valid && out_ready;
        start    = pending && (!out_valid || out_ready);
        n        = dllp_seq - head_seq + 1'b1;
        bad      = dllp_valid && (n > SEQ_W'(count));
        good     = dllp_valid && !bad;
        purge    = good && (n != '0);
        nak      = good && dllp_nak;
        n_c      = purge ? n[CW-1:0] : '0;
        expire   = (state == NORMAL) && (count != '0) && (timer == TW'(TIMEOUT - 1));
        req      = nak || (expire && !purge);

        head_nx  = head + PW'(n_c);
        count_p  = count - n_c;
        send_nx  = send + PW'(xfer);
        unsent_a = unsent - CW'(xfer);
        sent_a   = count - unsent_a;
        unsent_nx = unsent_a;
        // purging past the send point drags send forward to the new head
        if (purge && (n_c >= sent_a)) begin
            send_nx   = head_nx;
            unsent_nx = count_p;
        end
        unsent_nx = unsent_nx + CW'(wr);
        count_nx  = count_p + CW'(wr);

        go = start && (count_p != '0);
        if (go) begin
            send_nx   = head_nx;
            unsent_nx = count_p;
        end

        rnum_base = purge ? '0 : replay_num;
        overflow  = (rnum_base >= RW'(REPLAY_MAX));
        rnum_nx   = rnum_base;
        if (go) rnum_nx = overflow ? '0 : rnum_base + 1'b1;

        state_nx = state;
        if (state == REPLAY && unsent_nx == '0) state_nx = NORMAL;
        if (go) state_nx = REPLAY;

        pending_nx = (pending && !start) || req;

        timer_nx = timer;
        if (purge || start || expire || count_nx == '0) timer_nx = '0;
        else if (state == NORMAL && count != '0)        timer_nx = timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            data_mem[tail] <= tx_data;
            seq_mem[tail]  <= next_seq;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            send        <= '0;
            tail        <= '0;
            count       <= '0;
            unsent      <= '0;
            next_seq    <= '0;
            head_seq    <= '0;
            timer       <= '0;
            replay_num  <= '0;
            state       <= NORMAL;
            pending     <= 1'b0;
            alive       <= 1'b0;
            dllp_err    <= 1'b0;
            retrain_req <= 1'b0;
        end else begin
            head        <= head_nx;
            send        <= send_nx;
            tail        <= tail + PW'(wr);
            count       <= count_nx;
            unsent      <= unsent_nx;
            next_seq    <= next_seq + SEQ_W'(wr);
            head_seq    <= head_seq + SEQ_W'(n_c);
            timer       <= timer_nx;
            replay_num  <= rnum_nx;
            state       <= state_nx;
            pending     <= pending_nx;
            alive       <= 1'b1;
            dllp_err    <= bad;
            retrain_req <= go && overflow;
        end
    end
endmodule
